control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle control unit for the processor core. It sequences fetch, decode, execute, memory and write-back. It drives the instruction-register, PC, register-file, ALU, data-memory and I/O enables from the 6-bit opcode produced by the registered instruction decoder. It owns the memory and I/O handshakes and counts retired instructions. It sits between the instruction decoder and the datapath muxes/enables.

## Interface
- `OPCODE_W`, 6: opcode width; must match the decoder's opcode field.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clock` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching.
- `opcode` in OPCODE_W: registered decoder output; valid from EXEC onward.
- `zero` in 1: ALU equal flag, sampled in EXEC.
- `mem_ready` in 1: data-memory completion, sampled in MEM.
- `in_valid` in 1: external input word available.
- `out_ready` in 1: external sink accepts output.
- `ir_write` out 1: IR load enable.
- `pc_write` out 1: PC load enable.
- `pc_src` out 2: 0 = PC+1, 1 = PC+1+imm, 2 = jump target.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 2: destination field; 0 = rt, 1 = rd, 2 = link register 63.
- `alu_src_imm` out 1: ALU operand B is sign-extended 14-bit immediate.
- `alu_op` out 2: 0 = add, 1 = sub, 2 = funct-decoded.
- `dmem_read`, `dmem_write` out 1 each.
- `wb_sel` out 2: write-back source; 0 = ALU, 1 = memory, 2 = PC, 3 = input port.
- `in_req`, `out_valid` out 1 each.
- `halted` out 1.
- `illegal_op` out 1.
- `retired` out CNT_W.

## Operation
- States:
  - IDLE(0)
  - FETCH(1)
  - DECODE(2)
  - EXEC(3)
  - MEM(4)
  - WB(5)
  - IO_WAIT(6)
  - HALT(7)
- Opcodes:
  - R = 0
  - ADDI = 1
  - LW = 2
  - SW = 3
  - BEQ = 4
  - BNE = 5
  - J = 6
  - JAL = 7
  - IN = 8
  - OUT = 9
  - HALT = 63
  - All others illegal.
- IDLE: all enables 0; `start` = 1 moves to FETCH.
- FETCH: `ir_write` = 1, `pc_write` = 1, `pc_src` = 0. Next state is DECODE.
- DECODE: no enables asserted; the decoder registers its fields at the end of this cycle. Next state is EXEC.
- EXEC, by opcode:
  - R: `alu_op` = 2, go to WB.
  - ADDI: `alu_src_imm` = 1, `alu_op` = 0, go to WB.
  - LW/SW: `alu_src_imm` = 1, `alu_op` = 0, go to MEM.
  - BEQ/BNE: `alu_op` = 1. `pc_write` = (`zero` for BEQ, !`zero` for BNE) with `pc_src` = 1. Retire, go to FETCH.
  - J: `pc_write` = 1, `pc_src` = 2. Retire, go to FETCH.
  - JAL: same as J, plus `reg_write` = 1, `reg_dst` = 2, `wb_sel` = 2. Retire, go to FETCH.
  - IN/OUT: go to IO_WAIT.
  - HALT: go to HALT.
  - Illegal: `illegal_op` = 1 for this cycle only; not retired; go to FETCH.
- MEM:
  - `dmem_read` (LW) or `dmem_write` (SW) is held until `mem_ready`.
  - On `mem_ready`: LW goes to WB; SW retires and goes to FETCH.
- WB:
  - `reg_write` = 1 for exactly one cycle.
  - `reg_dst`: 1 for R, 0 otherwise.
  - `wb_sel`: 0 (ALU), 1 (LW) or 3 (IN).
  - Retire, go to FETCH.
- IO_WAIT:
  - IN: `in_req` held until `in_valid`, then go to WB.
  - OUT: `out_valid` held until `out_ready`, then retire and go to FETCH.
- HALT: `halted` = 1 and all enables 0. Exit only by reset; `start` is ignored.
- Retire means `retired` increments by 1 on the edge leaving the retiring state. It wraps modulo 2^CNT_W with no flag.
- The opcode is used only in EXEC, MEM, WB and IO_WAIT. It is stable there because the IR is written only in FETCH.

## Timing
- Asynchronous reset:
  - state = IDLE, `retired` = 0.
  - All outputs 0, including `pc_src`, `reg_dst`, `wb_sel` and `alu_op`.
- Reset asserted mid-instruction discards the instruction; no write enable survives the reset edge.
- Control outputs are Moore-style from the state register and the registered opcode. Exceptions: in EXEC, the branch `pc_write` follows `zero` combinationally; in MEM and IO_WAIT, the state transition follows `mem_ready`/`in_valid`/`out_ready` combinationally.
- Latency in cycles, FETCH through last state:
  - R/ADDI: 4
  - BEQ/BNE/J/JAL: 3
  - LW: 5 + memory waits
  - SW: 4 + memory waits
  - IN: 5 + waits
  - OUT: 4 + waits
- `mem_ready` already high on the first MEM cycle gives zero wait cycles. `in_valid` and `out_ready` behave the same in IO_WAIT.
- If `start` and reset release coincide, the FSM is in IDLE and leaves on the first edge where `start` = 1.

## Configuration
- `CTRL_IO_EN` defined:
  - IN/OUT decoded as above.
  - `in_req` and `out_valid` are live.
- `CTRL_IO_EN` undefined:
  - Opcodes 8 and 9 are illegal (`illegal_op` pulse, no retire).
  - IO_WAIT is unreachable.
  - `in_req` and `out_valid` are tied to 0.
  - `in_valid` and `out_ready` are ignored.

## Structure
- Shared package `cpu_pkg`:
  - State encoding.
  - Opcode constants.
  - `pc_src`, `reg_dst`, `wb_sel` and `alu_op` encodings.
  - Link register index 63.
- The decoder and the datapath import the same package.
- Natural sub-module: `retire_counter` (CNT_W up-counter with enable, async active-low clear).

## Test plan
- Reset, then `start` = 1, then R instruction: `ir_write` in cycle 1; `reg_write` = 1 with `reg_dst` = 1 and `wb_sel` = 0 in cycle 4 only; `retired` = 1.
- LW with `mem_ready` low for 3 cycles: `dmem_read` high for 4 cycles; WB has `wb_sel` = 1; total 8 cycles.
- BEQ, then BNE, each with `zero` = 1: BEQ EXEC has `pc_write` = 1 and `pc_src` = 1; BNE EXEC has `pc_write` = 0; both retire.
- JAL: EXEC asserts `pc_write`, `pc_src` = 2, `reg_write`, `reg_dst` = 2, `wb_sel` = 2 in the same cycle.
- Opcode 42, then HALT: one-cycle `illegal_op`, `retired` unchanged; then `halted` = 1 and stays high with `start` toggling.
- With `CTRL_IO_EN`: IN holds `in_req` until `in_valid`, then WB with `wb_sel` = 3. Without `CTRL_IO_EN`: IN pulses `illegal_op`. Also assert `reset_n` low mid-MEM: all outputs drop to 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the processor core (control FSM, decoder,
// datapath). Holds the control-FSM state encoding, opcode constants, the
// datapath mux-select encodings and the link-register index.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_IO_WAIT = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_LW   = 6'd2;
    localparam logic [5:0] OP_SW   = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd6;
    localparam logic [5:0] OP_JAL  = 6'd7;
    localparam logic [5:0] OP_IN   = 6'd8;
    localparam logic [5:0] OP_OUT  = 6'd9;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,   // PC + 1
        PC_SRC_BRANCH = 2'd1,   // PC + 1 + imm
        PC_SRC_JUMP   = 2'd2    // jump target
    } pc_src_t;

    typedef enum logic [1:0] {
        REG_DST_RT   = 2'd0,
        REG_DST_RD   = 2'd1,
        REG_DST_LINK = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,
        WB_IN  = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [5:0] LINK_REG = 6'd63;

endpackage

// File: rtl/control_fsm_retire_counter.sv
// retire_counter: CNT_W-bit up-counter of retired instructions.
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low clear
//   en      - increment by one on the next rising edge
//   count   - current count, wraps modulo 2^CNT_W
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle control unit. Sequences FETCH, DECODE, EXEC, MEM,
// WB and IO_WAIT from the registered decoder opcode, drives the datapath
// enables/mux selects, owns the memory and I/O handshakes and counts retired
// instructions.
//
// Build option: define CTRL_IO_EN to decode IN/OUT and enable the I/O
// handshake. Without it, opcodes 8/9 are illegal, IO_WAIT is unreachable and
// in_req/out_valid are constant 0.
//
// Ports:
//   clock, reset_n            - clock, asynchronous active-low reset
//   start                     - leave IDLE and begin fetching
//   opcode                    - registered decoder opcode (valid from EXEC)
//   zero                      - ALU equal flag (EXEC)
//   mem_ready                 - data-memory completion (MEM)
//   in_valid, out_ready       - external I/O handshake inputs
//   ir_write, pc_write        - IR / PC load enables
//   pc_src, reg_dst, wb_sel   - datapath mux selects (cpu_pkg encodings)
//   reg_write, alu_src_imm    - register write enable, ALU immediate select
//   alu_op                    - ALU operation select
//   dmem_read, dmem_write     - data-memory strobes
//   in_req, out_valid         - external I/O handshake outputs
//   halted, illegal_op        - status
//   retired                   - retired-instruction count
module control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic                alu_src_imm,
    output logic [1:0]          alu_op,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic [1:0]          wb_sel,
    output logic                in_req,
    output logic                out_valid,
    output logic                halted,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired
);

`ifdef CTRL_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    state_t state;
    logic   retire_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    case (opcode)
                        OP_R, OP_ADDI: state <= S_WB;
                        OP_LW, OP_SW:  state <= S_MEM;
                        OP_IN, OP_OUT: state <= IO_EN ? S_IO_WAIT : S_FETCH;
                        OP_HALT:       state <= S_HALT;
                        default:       state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) state <= (opcode == OP_LW) ? S_WB : S_FETCH;
                end
                S_WB: state <= S_FETCH;
                S_IO_WAIT: begin
                    if (opcode == OP_IN) begin
                        if (in_valid) state <= S_WB;
                    end else if (out_ready) begin
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register and the decoder's registered
    // opcode rather than re-registered here: the opcode only becomes valid on
    // the edge that enters EXEC, so EXEC controls cannot be precomputed a cycle
    // early. Both sources are flops, so the outputs stay Moore-style and all
    // drop to 0 the moment reset_n asserts.
    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_SEQ;
        reg_write   = 1'b0;
        reg_dst     = REG_DST_RT;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        wb_sel      = WB_ALU;
        in_req      = 1'b0;
        out_valid   = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        retire_en   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_SRC_SEQ;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: alu_op = ALU_FUNCT;
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_imm = 1'b1;
                        alu_op      = ALU_ADD;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op    = ALU_SUB;
                        pc_src    = PC_SRC_BRANCH;
                        // Branch decision follows the live ALU flag.
                        pc_write  = (opcode == OP_BEQ) ? zero : !zero;
                        retire_en = 1'b1;
                    end
                    OP_J: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_JUMP;
                        retire_en = 1'b1;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_JUMP;
                        reg_write = 1'b1;
                        reg_dst   = REG_DST_LINK;
                        wb_sel    = WB_PC;
                        retire_en = 1'b1;
                    end
                    OP_IN, OP_OUT: illegal_op = !IO_EN;
                    OP_HALT: ;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_LW) begin
                    dmem_read = 1'b1;
                end else begin
                    dmem_write = 1'b1;
                    retire_en  = mem_ready;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_R) ? REG_DST_RD : REG_DST_RT;
                if (opcode == OP_LW)      wb_sel = WB_MEM;
                else if (opcode == OP_IN) wb_sel = WB_IN;
                else                      wb_sel = WB_ALU;
                retire_en = 1'b1;
            end
            S_IO_WAIT: begin
                if (opcode == OP_IN) begin
                    in_req = IO_EN;
                end else begin
                    out_valid = IO_EN;
                    retire_en = out_ready;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (retire_en),
        .count  (retired)
    );

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed bench for control_fsm. Control outputs are packed
// into one vector ctl in the order
// {ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src_imm, alu_op,
//  dmem_read, dmem_write, wb_sel, in_req, out_valid, halted, illegal_op}
// and compared against hand-written expectations built with mk().
module tb_control_fsm;

    logic        clock = 1'b0;
    logic        reset_n, start, zero, mem_ready, in_valid, out_ready;
    logic [5:0]  opcode;
    logic        ir_write, pc_write, reg_write, alu_src_imm, dmem_read, dmem_write;
    logic        in_req, out_valid, halted, illegal_op;
    logic [1:0]  pc_src, reg_dst, alu_op, wb_sel;
    logic [31:0] retired;
    logic [17:0] ctl;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ret     = 0;

    control_fsm #(
        .OPCODE_W(6),
        .CNT_W   (32)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src_imm(alu_src_imm),
        .alu_op     (alu_op),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .wb_sel     (wb_sel),
        .in_req     (in_req),
        .out_valid  (out_valid),
        .halted     (halted),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    assign ctl = {ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src_imm, alu_op,
                  dmem_read, dmem_write, wb_sel, in_req, out_valid, halted, illegal_op};

    always #5 clock = ~clock;

    function automatic logic [17:0] mk(input logic ir, input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] rd, input logic imm,
                                       input logic [1:0] aop, input logic dr, input logic dw,
                                       input logic [1:0] wb, input logic irq, input logic ov,
                                       input logic h, input logic ill);
        return {ir, pcw, pcs, rw, rd, imm, aop, dr, dw, wb, irq, ov, h, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [17:0] f_vec;
        f_vec = mk(1,1,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,0,0,0);

        reset_n = 1'b0; start = 1'b0; opcode = 6'd0; zero = 1'b0;
        mem_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_ctl", ctl, 0);
        check("reset_retired", retired, 0);
        #10 reset_n = 1'b1;
        tick();
        check("idle_no_start", ctl, 0);

        // R: F D E WB
        start = 1'b1;
        tick();
        check("r_fetch", ctl, f_vec);
        start = 1'b0; opcode = 6'd0;
        tick(); check("r_decode", ctl, 0);
        tick(); check("r_exec", ctl, mk(0,0,2'd0,0,2'd0,0,2'd2,0,0,2'd0,0,0,0,0));
        tick(); check("r_wb", ctl, mk(0,0,2'd0,1,2'd1,0,2'd0,0,0,2'd0,0,0,0,0));
        check("r_ret_pending", retired, 0);
        tick(); exp_ret = 1;
        check("r_retired", retired, exp_ret);
        check("r_next_fetch", ctl, f_vec);

        // LW with three memory wait cycles: F D E M M M M WB = 8 cycles
        opcode = 6'd2; mem_ready = 1'b0;
        tick(); check("lw_decode", ctl, 0);
        tick(); check("lw_exec", ctl, mk(0,0,2'd0,0,2'd0,1,2'd0,0,0,2'd0,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            tick(); check("lw_mem_wait", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,1,0,2'd0,0,0,0,0));
        end
        tick(); mem_ready = 1'b1;
        check("lw_mem_ready", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,1,0,2'd0,0,0,0,0));
        tick(); mem_ready = 1'b0;
        check("lw_wb", ctl, mk(0,0,2'd0,1,2'd0,0,2'd0,0,0,2'd1,0,0,0,0));
        tick(); exp_ret++;
        check("lw_retired", retired, exp_ret);
        check("lw_next_fetch", ctl, f_vec);

        // BEQ, zero=1: branch taken; pc_write follows zero combinationally
        opcode = 6'd4; zero = 1'b1;
        tick(); tick();
        check("beq_exec", ctl, mk(0,1,2'd1,0,2'd0,0,2'd1,0,0,2'd0,0,0,0,0));
        zero = 1'b0; #1;
        check("beq_zero_comb", {31'd0, pc_write}, 0);
        zero = 1'b1;
        tick(); exp_ret++;
        check("beq_retired", retired, exp_ret);

        // BNE, zero=1: not taken, still retires
        opcode = 6'd5;
        tick(); tick();
        check("bne_exec", ctl, mk(0,0,2'd1,0,2'd0,0,2'd1,0,0,2'd0,0,0,0,0));
        tick(); exp_ret++;
        check("bne_retired", retired, exp_ret);
        zero = 1'b0;

        // JAL: all link controls in the EXEC cycle
        opcode = 6'd7;
        tick(); tick();
        check("jal_exec", ctl, mk(0,1,2'd2,1,2'd2,0,2'd0,0,0,2'd2,0,0,0,0));
        tick(); exp_ret++;
        check("jal_retired", retired, exp_ret);
        check("jal_next_fetch", ctl, f_vec);

        // ADDI
        opcode = 6'd1;
        tick(); tick();
        check("addi_exec", ctl, mk(0,0,2'd0,0,2'd0,1,2'd0,0,0,2'd0,0,0,0,0));
        tick();
        check("addi_wb", ctl, mk(0,0,2'd0,1,2'd0,0,2'd0,0,0,2'd0,0,0,0,0));
        tick(); exp_ret++;
        check("addi_retired", retired, exp_ret);

        // SW with mem_ready already high: zero wait cycles
        opcode = 6'd3; mem_ready = 1'b1;
        tick(); tick();
        check("sw_exec", ctl, mk(0,0,2'd0,0,2'd0,1,2'd0,0,0,2'd0,0,0,0,0));
        tick();
        check("sw_mem", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,1,2'd0,0,0,0,0));
        check("sw_ret_pending", retired, exp_ret);
        tick(); exp_ret++; mem_ready = 1'b0;
        check("sw_retired", retired, exp_ret);
        check("sw_next_fetch", ctl, f_vec);

        // Illegal opcode 42: one-cycle pulse, no retire
        opcode = 6'd42;
        tick(); tick();
        check("illegal_exec", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,0,0,1));
        tick();
        check("illegal_cleared", ctl, f_vec);
        check("illegal_no_retire", retired, exp_ret);

`ifdef CTRL_IO_EN
        // IN: in_req held until in_valid, then WB from the input port
        opcode = 6'd8; in_valid = 1'b0;
        tick(); tick();
        check("in_exec", ctl, 0);
        tick(); check("in_wait1", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,1,0,0,0));
        tick(); check("in_wait2", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,1,0,0,0));
        in_valid = 1'b1;
        check("in_valid_cycle", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,1,0,0,0));
        tick(); in_valid = 1'b0;
        check("in_wb", ctl, mk(0,0,2'd0,1,2'd0,0,2'd0,0,0,2'd3,0,0,0,0));
        tick(); exp_ret++;
        check("in_retired", retired, exp_ret);

        // OUT with out_ready already high
        opcode = 6'd9; out_ready = 1'b1;
        tick(); tick();
        tick(); check("out_wait", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,1,0,0));
        tick(); exp_ret++; out_ready = 1'b0;
        check("out_retired", retired, exp_ret);
        check("out_next_fetch", ctl, f_vec);
`else
        // IN/OUT are illegal without the I/O option; handshake inputs ignored
        opcode = 6'd8; in_valid = 1'b1; out_ready = 1'b1;
        tick(); tick();
        check("in_illegal", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,0,0,1));
        tick();
        check("in_illegal_next", ctl, f_vec);
        check("in_no_retire", retired, exp_ret);
        opcode = 6'd9;
        tick(); tick();
        check("out_illegal", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,0,0,1));
        tick();
        check("out_no_retire", retired, exp_ret);
        in_valid = 1'b0; out_ready = 1'b0;
`endif

        // Reset asserted mid-MEM: everything drops at once
        opcode = 6'd2; mem_ready = 1'b0;
        tick(); tick(); tick();
        check("rst_in_mem", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,1,0,2'd0,0,0,0,0));
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ctl", ctl, 0);
        check("rst_mid_retired", retired, 0);
        exp_ret = 0;
        // Release reset together with start: leaves IDLE on the next edge
        #2 reset_n = 1'b1; start = 1'b1;
        tick();
        check("rst_start_fetch", ctl, f_vec);
        start = 1'b0;

        // HALT: sticky, start ignored
        opcode = 6'd63;
        tick(); tick();
        check("halt_exec", ctl, 0);
        tick();
        check("halt_state", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,0,1,0));
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            tick();
            check("halt_sticky", ctl, mk(0,0,2'd0,0,2'd0,0,2'd0,0,0,2'd0,0,0,1,0));
        end
        check("halt_retired", retired, exp_ret);
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
